// File: rtl/fet_cell_tester.sv
// Sequences the A/B truth-table vectors through a discrete-FET gate board and checks the
// synchronised Y against the selected cell. Optional stability recheck: FET_TESTER_STABILITY_EN.
module fet_cell_tester #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] cell_sel,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic       err_cfg,
    output logic       unstable
);

    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 2..255");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_HOLD, S_RECHECK, S_NEXT, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cell_q, cell_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       y_meta_q, y_sync_q;
    logic       dut_a_q, dut_a_d, dut_b_q, dut_b_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_q, fail_d;
    logic       err_q, err_d;
    logic       unst_q, unst_d;
`ifdef FET_TESTER_STABILITY_EN
    logic       y_first_q, y_first_d;
`endif

    logic       one_in;
    logic       last_vec;
    logic [1:0] idx_nxt;

    function automatic logic expect_y(input logic [3:0] sel, input logic a, input logic b);
        case (sel)
            4'd0:    return ~a;
            4'd1:    return a;
            4'd2:    return ~(a & b);
            4'd3:    return a & b;
            4'd4:    return a & ~b;
            4'd5:    return a | b;
            4'd6:    return ~(a | b);
            4'd7:    return a | ~b;
            4'd8:    return a ^ b;
            4'd9:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cell_d   = cell_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dut_a_d  = dut_a_q;
        dut_b_d  = dut_b_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        unst_d   = unst_q;
`ifdef FET_TESTER_STABILITY_EN
        y_first_d = y_first_q;
`endif
        // Single-input cells only exercise A, so B stays low and odd vectors are skipped.
        one_in   = (cell_q <= 4'd1);
        last_vec = one_in ? (idx_q == 2'd2) : (idx_q == 2'd3);
        idx_nxt  = one_in ? 2'd2 : idx_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    cell_d  = cell_sel;
                    idx_d   = 2'd0;
                    pass_d  = 1'b0;
                    fail_d  = 4'b0000;
                    unst_d  = 1'b0;
                    err_d   = (cell_sel >= 4'd10);
                    dut_a_d = 1'b0;
                    dut_b_d = 1'b0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_d   = 8'(SETTLE_CYCLES);
                state_d = err_q ? S_DONE : S_SETTLE;
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (y_sync_q != expect_y(cell_q, idx_q[1], idx_q[0])) begin
                    fail_d[idx_q] = 1'b1;
                end
`ifdef FET_TESTER_STABILITY_EN
                y_first_d = y_sync_q;
                cnt_d     = 8'(HOLD_CYCLES);
                state_d   = S_HOLD;
`else
                state_d   = S_NEXT;
`endif
            end
`ifdef FET_TESTER_STABILITY_EN
            S_HOLD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_RECHECK;
                end
            end
            S_RECHECK: begin
                if (y_sync_q != y_first_q) begin
                    unst_d        = 1'b1;
                    fail_d[idx_q] = 1'b1;
                end
                state_d = S_NEXT;
            end
`endif
            S_NEXT: begin
                if (last_vec) begin
                    dut_a_d = 1'b0;
                    dut_b_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_nxt;
                    dut_a_d = idx_nxt[1];
                    dut_b_d = one_in ? 1'b0 : idx_nxt[0];
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = (fail_q == 4'b0000) && !unst_q && !err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort freezes the results exactly as they stood and silently returns to idle.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            dut_a_d = 1'b0;
            dut_b_d = 1'b0;
            done_d  = 1'b0;
            pass_d  = pass_q;
            fail_d  = fail_q;
            err_d   = err_q;
            unst_d  = unst_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cell_q   <= 4'd0;
            idx_q    <= 2'd0;
            cnt_q    <= 8'd0;
            y_meta_q <= 1'b0;
            y_sync_q <= 1'b0;
            dut_a_q  <= 1'b0;
            dut_b_q  <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 4'b0000;
            err_q    <= 1'b0;
            unst_q   <= 1'b0;
`ifdef FET_TESTER_STABILITY_EN
            y_first_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cell_q   <= cell_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            y_meta_q <= dut_y;
            y_sync_q <= y_meta_q;
            dut_a_q  <= dut_a_d;
            dut_b_q  <= dut_b_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            unst_q   <= unst_d;
`ifdef FET_TESTER_STABILITY_EN
            y_first_q <= y_first_d;
`endif
        end
    end

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_q;
    assign err_cfg   = err_q;
`ifdef FET_TESTER_STABILITY_EN
    assign unstable  = unst_q;
`else
    assign unstable  = 1'b0;
`endif

endmodule
